sam_vaddr_gen: RTL and testbench

- Video-side address generator: the display-memory reader that complements the CPU-side SAM address and select decode.
- Produces the 16-bit RAM address the VDG reads. It follows the VDG timing strobes: DA0 for byte clock, HS_n for line, FS_n for field.
- Applies the SAM mode register (V2..V0) for X/Y division and the display offset (F6..F0) for the field base.
- Sits between the SAM register file and the RAM arbiter's video port.

---
 rtl/sam_vaddr_gen.sv | 104 ++++++++++
 tb/tb_sam_vaddr_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sam_vaddr_gen.sv
// Video-side SAM address generator: follows the VDG da0/hs_n/fs_n strobes and
// produces the display RAM address, honouring the V2..V0 divide mode and F6..F0 base.
module sam_vaddr_gen #(
  parameter int unsigned ROW_BYTES  = 32,
  parameter int unsigned BASE_SHIFT = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  mode,
  input  logic [6:0]  disp_offset,
  input  logic        da0,
  input  logic        hs_n,
  input  logic        fs_n,
  output logic [15:0] vaddr,
  output logic        vfetch
);

  localparam int unsigned AW = 16;
  localparam int unsigned YW = 4;

  logic          r_da0_q;
  logic          r_hs_q;
  logic          r_fs_q;
  logic          r_xphase;
  logic [YW-1:0] r_ycnt;
  logic [AW-1:0] r_row_start;

  logic          w_da0_fall;
  logic          w_hs_fall;
  logic          w_fs_fall;
  logic          w_xdiv2;
  logic [YW-1:0] w_ylast;
  logic [AW-1:0] w_base;
  logic          w_unused_row;

  // Row length is implied by how many da0 strobes the VDG issues per line.
  assign w_unused_row = ^ROW_BYTES;

  assign w_da0_fall = r_da0_q & ~da0;
  assign w_hs_fall  = r_hs_q  & ~hs_n;
  assign w_fs_fall  = r_fs_q  & ~fs_n;
  assign w_base     = AW'(disp_offset) << BASE_SHIFT;
  assign w_xdiv2    = mode[0] && (mode != 3'b111);

  // Last Y repeat index (Ydiv-1) for the current mode.
  always_comb begin
    w_ylast = YW'(0);
    case (mode)
      3'b000:  w_ylast = YW'(11);
      3'b001:  w_ylast = YW'(2);
      3'b010:  w_ylast = YW'(2);
      3'b011:  w_ylast = YW'(1);
      3'b100:  w_ylast = YW'(1);
      default: w_ylast = YW'(0);
    endcase
  end

  // Strobe sampling plus field/line/byte actions in fs > hs > da0 priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_da0_q     <= 1'b1;
      r_hs_q      <= 1'b1;
      r_fs_q      <= 1'b1;
      r_xphase    <= 1'b0;
      r_ycnt      <= '0;
      r_row_start <= '0;
      vaddr       <= '0;
      vfetch      <= 1'b0;
    end else begin
      r_da0_q <= da0;
      r_hs_q  <= hs_n;
      r_fs_q  <= fs_n;
      vfetch  <= 1'b0;
      if (w_fs_fall) begin
        vaddr       <= w_base;
        r_row_start <= w_base;
        r_ycnt      <= '0;
        r_xphase    <= 1'b0;
      end else if (w_hs_fall) begin
        r_xphase <= 1'b0;
        // >= so a mode change that shrinks Ydiv still closes the row.
        if (r_ycnt >= w_ylast) begin
          r_ycnt      <= '0;
          r_row_start <= vaddr;
        end else begin
          r_ycnt <= r_ycnt + YW'(1);
          vaddr  <= r_row_start;
        end
      end else if (w_da0_fall) begin
        if (w_xdiv2) begin
          r_xphase <= ~r_xphase;
          if (r_xphase) begin
            vaddr  <= vaddr + AW'(1);
            vfetch <= 1'b1;
          end
        end else begin
          vaddr  <= vaddr + AW'(1);
          vfetch <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sam_vaddr_gen.sv
// Self-checking bench for sam_vaddr_gen: directed scenarios plus randomized
// strobe/mode traffic compared against an event-level reference model.
module tb_sam_vaddr_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  mode;
  logic [6:0]  disp_offset;
  logic        da0;
  logic        hs_n;
  logic        fs_n;
  logic [15:0] vaddr;
  logic        vfetch;

  int n_checks = 0;
  int n_errors = 0;
  int fetch_cnt;

  // Reference model state
  int m_vaddr;
  int m_row;
  int m_y;
  bit m_xph;

  sam_vaddr_gen #(.ROW_BYTES(32), .BASE_SHIFT(9)) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .disp_offset(disp_offset),
    .da0(da0), .hs_n(hs_n), .fs_n(fs_n), .vaddr(vaddr), .vfetch(vfetch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ydiv_of(input logic [2:0] md);
    case (md)
      3'b000:  return 12;
      3'b001:  return 3;
      3'b010:  return 3;
      3'b011:  return 2;
      3'b100:  return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int xdiv_of(input logic [2:0] md);
    case (md)
      3'b001, 3'b011, 3'b101: return 2;
      default:                return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_vaddr = 0; m_row = 0; m_y = 0; m_xph = 1'b0;
  endtask

  task automatic model_event(input bit da, input bit hs, input bit fs, output bit fetch);
    fetch = 1'b0;
    if (fs) begin
      m_vaddr = int'(disp_offset) * 512;
      m_row   = m_vaddr;
      m_y     = 0;
      m_xph   = 1'b0;
    end else if (hs) begin
      m_xph = 1'b0;
      if (m_y >= ydiv_of(mode) - 1) begin
        m_y   = 0;
        m_row = m_vaddr;
      end else begin
        m_y++;
        m_vaddr = m_row;
      end
    end else if (da) begin
      if (xdiv_of(mode) == 1 || m_xph) begin
        m_vaddr = (m_vaddr + 1) % 65536;
        fetch   = 1'b1;
      end
      if (xdiv_of(mode) == 2) m_xph = ~m_xph;
    end
  endtask

  // One-clk low pulse on the chosen strobes; checks idle cycle and the action cycle.
  task automatic pulse(input bit da, input bit hs, input bit fs);
    bit exp_fetch;
    @(negedge clk);
    check("vfetch_idle", {31'd0, vfetch}, 32'd0);
    check("vaddr_hold", {16'd0, vaddr}, m_vaddr);
    if (da) da0 = 1'b0;
    if (hs) hs_n = 1'b0;
    if (fs) fs_n = 1'b0;
    model_event(da, hs, fs, exp_fetch);
    @(negedge clk);
    check("vaddr", {16'd0, vaddr}, m_vaddr);
    check("vfetch", {31'd0, vfetch}, {31'd0, exp_fetch});
    if (vfetch) fetch_cnt++;
    da0 = 1'b1; hs_n = 1'b1; fs_n = 1'b1;
  endtask

  task automatic bytes(input int n);
    for (int i = 0; i < n; i++) pulse(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    bit [2:0] ev;
    int       prev;
    reset_n = 1'b0; mode = 3'b000; disp_offset = 7'h00;
    da0 = 1'b1; hs_n = 1'b1; fs_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_vaddr", {16'd0, vaddr}, 32'h0);
    check("reset_vfetch", {31'd0, vfetch}, 32'd0);
    reset_n = 1'b1;

    // Asynchronous reset mid-count, while vfetch is high
    bytes(5);
    @(negedge clk);
    da0 = 1'b0;
    @(posedge clk);
    #1;
    check("pre_reset_vfetch", {31'd0, vfetch}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_reset_vaddr", {16'd0, vaddr}, 32'h0);
    check("async_reset_vfetch", {31'd0, vfetch}, 32'd0);
    da0 = 1'b1;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    disp_offset = 7'h02;
    pulse(1'b0, 1'b0, 1'b1);
    check("fs_base_0400", {16'd0, vaddr}, 32'h0400);

    // Mode 000: X1 Y12
    mode = 3'b000; disp_offset = 7'h00;
    pulse(1'b0, 1'b0, 1'b1);
    fetch_cnt = 0;
    bytes(32);
    check("m0_row_end", {16'd0, vaddr}, 32'h0020);
    check("m0_fetches", fetch_cnt, 32);
    pulse(1'b0, 1'b1, 1'b0);
    check("m0_repeat", {16'd0, vaddr}, 32'h0000);
    for (int l = 2; l <= 12; l++) begin
      bytes(32);
      pulse(1'b0, 1'b1, 1'b0);
    end
    check("m0_advance", {16'd0, vaddr}, 32'h0020);
    bytes(32);
    check("m0_row2", {16'd0, vaddr}, 32'h0040);

    // Mode 001: X2 Y3
    mode = 3'b001;
    pulse(1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 2; r++) begin
      for (int rep = 0; rep < 3; rep++) begin
        fetch_cnt = 0;
        bytes(32);
        check("m1_row_end", {16'd0, vaddr}, 32'(16 * (r + 1)));
        check("m1_fetches", fetch_cnt, 16);
        pulse(1'b0, 1'b1, 1'b0);
        check("m1_after_hs", {16'd0, vaddr}, 32'(rep == 2 ? 16 * (r + 1) : 16 * r));
      end
    end

    // Mode 110 full field
    mode = 3'b110; disp_offset = 7'h04;
    pulse(1'b0, 1'b0, 1'b1);
    for (int l = 0; l < 192; l++) begin
      bytes(32);
      pulse(1'b0, 1'b1, 1'b0);
    end
    check("m6_field_end", {16'd0, vaddr}, 32'h2000);

    // Priority fs over hs
    disp_offset = 7'h00;
    pulse(1'b0, 1'b0, 1'b1);
    bytes(16'h0123);
    check("prio_setup", {16'd0, vaddr}, 32'h0123);
    disp_offset = 7'h01;
    pulse(1'b0, 1'b1, 1'b1);
    check("prio_fs_hs", {16'd0, vaddr}, 32'h0200);
    // da0 with hs: line action only (Y1 advance leaves vaddr unchanged)
    bytes(7);
    prev = m_vaddr;
    pulse(1'b1, 1'b1, 1'b0);
    check("prio_da_hs", {16'd0, vaddr}, prev);

    // Wrap at top of memory
    disp_offset = 7'h7F;
    pulse(1'b0, 1'b0, 1'b1);
    check("wrap_base", {16'd0, vaddr}, 32'hFE00);
    bytes(512);
    check("wrap_zero", {16'd0, vaddr}, 32'h0000);
    pulse(1'b0, 1'b1, 1'b0);
    check("wrap_hs", {16'd0, vaddr}, 32'h0000);

    // Randomized strobes with live mode/offset changes
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 40) == 0) mode = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 60) == 0) disp_offset = 7'($urandom);
      case ($urandom_range(0, 99)) inside
        [0:69]:  ev = 3'b001;
        [70:84]: ev = 3'b010;
        [85:87]: ev = 3'b100;
        [88:95]: ev = 3'($urandom_range(1, 7));
        default: ev = 3'b000;
      endcase
      pulse(ev[0], ev[1], ev[2]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
